// File: rtl/imem_prog_ctrl_if.sv
// Bundle between the program-load controller and its byte stream, instruction memory and PC.
// The master drives the load request, stream bytes and fetch address; the slave is the controller.
interface imem_prog_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [31:0]       fetch_addr;
  logic [31:0]       mem_raddr;
  logic              cpu_stall;
  logic              fetch_fault;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_len, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_stall, fetch_fault, load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cpu_stall, fetch_fault, load_busy, load_done, load_err
  );
endinterface

// File: rtl/imem_prog_ctrl.sv
// Instruction-memory program loader: streams bytes into memory, zero-pads to a word, then releases the CPU.
// States: HALT no program | LOAD accept bytes | PAD zero-fill to word | DRAIN last write lands | RUN CPU released
module imem_prog_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic             i_clk,
  input logic             i_reset,
  imem_prog_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_HALT,
    S_LOAD,
    S_PAD,
    S_DRAIN,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [31:0]     FETCH_MAX = 32'(DEPTH - 4);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_len;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_err;
  logic              r_done;

  logic [ADDR_W:0]   w_count_inc;
  logic              w_len_ok;
  logic              w_start_ok;
  logic              w_ready;
  logic              w_xfer;
  logic              w_pad_step;
  logic              w_last_byte;
  logic              w_pad_done;

  assign w_len_ok    = (bus.load_len != '0) && (bus.load_len <= LEN_MAX);
  assign w_start_ok  = bus.load_start && w_len_ok;
  assign w_count_inc = r_count + CNT_ONE;
  assign w_xfer      = w_ready && bus.byte_valid;
  assign w_pad_step  = (r_state == S_PAD) && !w_start_ok;
  assign w_last_byte = (w_count_inc == r_len);
  assign w_pad_done  = (w_count_inc[1:0] == 2'b00);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A valid restart wins over whatever the current state was doing.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start_ok) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer && w_last_byte) begin
            w_state_nxt = (r_len[1:0] != 2'b00) ? S_PAD : S_DRAIN;
          end
        end
        S_PAD: begin
          if (w_pad_done) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    // Ready is withheld during a restart cycle so no byte is accepted and then dropped.
    w_ready         = (r_state == S_LOAD) && !w_start_ok;
    bus.byte_ready  = w_ready;
    bus.cpu_stall   = (r_state != S_RUN);
    bus.load_busy   = (r_state == S_LOAD) || (r_state == S_PAD) || (r_state == S_DRAIN);
    bus.fetch_fault = 1'b0;
    bus.mem_raddr   = '0;
    if (r_state == S_RUN) begin
      bus.fetch_fault = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr > FETCH_MAX);
      bus.mem_raddr   = bus.fetch_fault ? 32'h0 : bus.fetch_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we <= w_xfer || w_pad_step;
      if (w_xfer) begin
        r_waddr <= r_count[ADDR_W-1:0];
        r_wdata <= bus.byte_data;
      end else if (w_pad_step) begin
        r_waddr <= r_count[ADDR_W-1:0];
        r_wdata <= 8'h00;
      end
      if (w_start_ok) begin
        r_count <= '0;
        r_len   <= bus.load_len;
      end else if (w_xfer || w_pad_step) begin
        r_count <= w_count_inc;
      end
      if (bus.load_start) begin
        r_err <= !w_len_ok;
      end
      r_done <= (r_state == S_DRAIN) && (w_state_nxt == S_RUN);
    end
  end

  assign bus.mem_we    = r_we;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.load_err  = r_err;
  assign bus.load_done = r_done;

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Randomized scoreboard bench for imem_prog_ctrl: expected memory writes are queued as bytes are
// accepted, and a negedge monitor pops and compares every mem_we cycle.
module tb_imem_prog_ctrl;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_prog_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  imem_prog_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  prog[0:DEPTH-1];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.mem_we !== 1'b0) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", bus.mem_waddr, bus.mem_wdata);
      end else begin
        chk("mem_write", {16'h0, bus.mem_waddr, bus.mem_wdata}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int len);
    bus.load_start = 1'b1;
    bus.load_len   = len[ADDR_W:0];
    tick();
    bus.load_start = 1'b0;
  endtask

  // Streams prog[0..nsend-1]; when the whole program is sent, also checks release timing.
  task automatic send(int len, int nsend, bit gaps);
    int idx   = 0;
    int guard = 0;
    int k     = 0;
    int pad   = 0;
    while (1) begin
      bus.byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = prog[idx];
      @(negedge clk);
      guard++;
      if (bus.byte_valid && bus.byte_ready) begin
        sb_q.push_back({idx[7:0], prog[idx]});
        idx++;
      end
      if (idx >= nsend || guard >= 4000) break;
      tick();
    end
    if (idx < nsend) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: accepted %0d of %0d bytes", idx, nsend);
    end
    if (nsend < len) begin
      tick();
      bus.byte_valid = 1'b0;
      return;
    end
    for (int a = len; a % 4 != 0; a++) begin
      sb_q.push_back({a[7:0], 8'h00});
      pad++;
    end
    do begin
      tick();
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hEE;
      @(negedge clk);
      k++;
      if (!bus.load_done) chk("stall_before_run", bus.cpu_stall, 1);
    end while (!bus.load_done && k < 60);
    chk("release_latency", k, 2 + pad);
    chk("stall_in_run", bus.cpu_stall, 0);
    chk("busy_in_run", bus.load_busy, 0);
    tick();
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", bus.load_done, 0);
    chk("writes_drained", sb_q.size(), 0);
    tick();
  endtask

  task automatic check_fetch(logic [31:0] addr);
    logic        exp_fault;
    logic [31:0] exp_raddr;
    bus.fetch_addr = addr;
    #1;
    exp_fault = (addr % 4 != 0) || (addr > DEPTH - 4);
    exp_raddr = exp_fault ? 32'h0 : addr;
    chk("fetch_fault", bus.fetch_fault, exp_fault);
    chk("mem_raddr", bus.mem_raddr, exp_raddr);
  endtask

  task automatic check_reset_vals();
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_waddr", bus.mem_waddr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 1);
    chk("rst_load_busy", bus.load_busy, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_load_err", bus.load_err, 0);
    chk("rst_mem_raddr", bus.mem_raddr, 0);
    chk("rst_fetch_fault", bus.fetch_fault, 0);
  endtask

  initial begin
    int len;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.fetch_addr = 32'h4;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    tick();

    // invalid lengths from HALT, then a valid one clears the error
    start(0);
    @(negedge clk);
    chk("err_len0", bus.load_err, 1);
    chk("halt_stall_len0", bus.cpu_stall, 1);
    chk("halt_busy_len0", bus.load_busy, 0);
    tick();
    start(DEPTH + 1);
    @(negedge clk);
    chk("err_len257", bus.load_err, 1);
    chk("halt_stall_len257", bus.cpu_stall, 1);
    chk("halt_ready_len257", bus.byte_ready, 0);
    tick();
    for (int i = 0; i < 4; i++) prog[i] = 8'(8'h10 + i);
    start(4);
    @(negedge clk);
    chk("err_cleared", bus.load_err, 0);
    chk("busy_in_load", bus.load_busy, 1);
    tick();
    send(4, 4, 1'b0);

    // basic 8-byte program
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h01; prog[5] = 8'h02; prog[6] = 8'h03; prog[7] = 8'h04;
    start(8);
    send(8, 8, 1'b0);
    check_fetch(32'h4);

    // non-word length needs two pad bytes
    for (int i = 0; i < 6; i++) prog[i] = 8'(8'hAA + i);
    start(6);
    send(6, 6, 1'b0);

    // gapped stream
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    start(16);
    send(16, 16, 1'b1);

    // fetch path in RUN
    check_fetch(32'h2);
    check_fetch(32'hFE);
    check_fetch(32'hFC);
    check_fetch(32'h0);
    check_fetch(32'h100);
    check_fetch(32'hFFFF_FFFC);
    for (int i = 0; i < 12; i++) check_fetch($urandom_range(0, 300));

    // invalid length while running keeps the CPU released
    start(300);
    @(negedge clk);
    chk("err_in_run", bus.load_err, 1);
    chk("stall_after_bad_run", bus.cpu_stall, 0);
    tick();

    // restart mid-load
    for (int i = 0; i < 8; i++) prog[i] = 8'($urandom);
    start(8);
    send(8, 3, 1'b1);
    for (int i = 0; i < 5; i++) prog[i] = 8'($urandom);
    start(5);
    send(5, 5, 1'b1);

    // random loads
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) prog[i] = 8'($urandom);
      start(len);
      send(len, len, 1'($urandom_range(0, 1)));
    end

    // full-depth program
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
    start(DEPTH);
    send(DEPTH, DEPTH, 1'b0);
    check_fetch(32'hFC);

    // reset in the middle of a load
    for (int i = 0; i < 8; i++) prog[i] = 8'($urandom);
    start(8);
    send(8, 3, 1'b0);
    reset = 1'b1;
    bus.fetch_addr = 32'h4;
    @(negedge clk);
    check_reset_vals();
    sb_q.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
    start(4);
    send(4, 4, 1'b0);
    check_fetch(32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
